// File: rtl/bram_read_streamer.sv
// Streams an address range out of a 1-cycle-latency BRAM as a valid/ready word stream with a last flag.
// Optional build macro BRAM_READ_STREAMER_REVERSE_EN adds a reverse port for decrementing address walks.
module bram_read_streamer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef BRAM_READ_STREAMER_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_write_en,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]      DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]      CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  // Handshake: a word moves on any rising edge where out_valid & out_ready are both 1;
  // out_valid never drops and out_data/out_last never change until that happens.

  state_t state, next_state;

  logic [ADDR_WIDTH:0]   remaining;
  logic                  tag_valid;
  logic                  tag_last;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [PTR_W:0]        outstanding;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  accept;
  logic                  zero_start;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  finish;

`ifdef BRAM_READ_STREAMER_REVERSE_EN
  logic dir;
  assign next_addr = dir ? (bram_addr - ADDR_ONE) : (bram_addr + ADDR_ONE);
`else
  assign next_addr = bram_addr + ADDR_ONE;
`endif

  // Reads in flight are counted against the FIFO so every returning word has a slot.
  assign outstanding = count + {{PTR_W{1'b0}}, tag_valid};
  assign accept      = (state == IDLE) && start && (length != '0);
  assign zero_start  = (state == IDLE) && start && (length == '0);
  assign issue       = (state == ISSUE) && (remaining != '0) && (outstanding < DEPTH_C);
  assign push        = tag_valid;
  assign pop         = out_valid && out_ready;
  assign finish      = (state == DRAIN) && pop && out_last;

  assign out_valid     = (count != '0);
  assign out_data      = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last      = out_valid & fifo_last[rd_ptr];
  assign busy          = (state != IDLE);
  assign bram_write_en = 1'b0;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (issue && (remaining == LEN_ONE)) next_state = DRAIN;
      DRAIN:   if (finish) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bram_addr <= '0;
      remaining <= '0;
      tag_valid <= 1'b0;
      tag_last  <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
`ifdef BRAM_READ_STREAMER_REVERSE_EN
      dir       <= 1'b0;
`endif
    end else begin
      done <= finish || zero_start;
      if (accept) begin
        bram_addr <= start_addr;
        remaining <= length;
`ifdef BRAM_READ_STREAMER_REVERSE_EN
        dir       <= reverse;
`endif
      end else if (issue) begin
        bram_addr <= next_addr;
        remaining <= remaining - LEN_ONE;
      end
      tag_valid <= issue;
      tag_last  <= issue && (remaining == LEN_ONE);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_data/out_last are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_data;
      fifo_last[wr_ptr] <= tag_last;
    end
  end

endmodule

// File: tb/tb_bram_read_streamer.sv
// Self-checking bench for bram_read_streamer: BRAM model preloaded with mem[i]=i+8'h10,
// expected {last,data} words queued at start and compared at each output handshake.
module tb_bram_read_streamer;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       reverse;
  logic [3:0] bram_addr;
  logic       bram_write_en;
  logic [7:0] bram_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mem [16];

  bram_read_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .length(length),
`ifdef BRAM_READ_STREAMER_REVERSE_EN
    .reverse(reverse),
`endif
    .bram_addr(bram_addr), .bram_write_en(bram_write_en), .bram_data(bram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset / BRAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

  always @(posedge clk) bram_data <= mem[bram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: pulse start on one cycle, push the expected stream into the scoreboard
  task automatic start_xfer(input logic [3:0] a, input logic [4:0] n, input logic rev);
    logic [3:0] ai;
    @(negedge clk);
    start = 1'b1; start_addr = a; length = n; reverse = rev;
    for (int i = 0; i < int'(n); i++) begin
      ai = reverse ? (a - 4'(i)) : (a + 4'(i));
      exp_q.push_back({(i == int'(n) - 1), mem[ai]});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; start_addr = '0; length = '0; reverse = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bram_addr, out_valid, out_data, out_last, busy, done, bram_write_en, state_dbg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%h valid=%b data=%h last=%b busy=%b done=%b we=%b st=%0d want all 0",
               bram_addr, out_valid, out_data, out_last, busy, done, bram_write_en, state_dbg);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int k, first, last_k;
    logic [8:0] e;
    out_ready = 1'b1;
    start_xfer(4'd3, 5'd5, 1'b0);
    tests++;
    if (busy !== 1'b1 || state_dbg !== 2'd1) begin
      fails++; $display("FAIL basic_busy: busy=%b state=%0d want 1/1", busy, state_dbg);
    end
    first = -1; last_k = -1; k = 1;
    while (last_k < 0 && k < 40) begin
      if (out_valid === 1'b1) begin
        if (first < 0) first = k;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL basic_extra: unexpected word %h", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            fails++; $display("FAIL basic_word: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
        if (out_last === 1'b1) last_k = k;
      end
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL basic_early_done: done=%b at cycle %0d want 0", done, k); end
      @(negedge clk); k++;
    end
    tests++;
    if (first !== 3) begin fails++; $display("FAIL basic_latency: first valid cycle %0d want 3", first); end
    tests++;
    if (last_k - first !== 4) begin fails++; $display("FAIL basic_bubbles: span %0d want 4", last_k - first); end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_done: done=%b busy=%b want 1/0", done, busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_backpressure();
    int k, got;
    logic stalled;
    logic [8:0] held, e;
    out_ready = 1'b1;
    start_xfer(4'd3, 5'd5, 1'b0);
    k = 1; got = 0; stalled = 1'b0; held = '0;
    while (got < 5 && k < 80) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      if (k == 2) begin start = 1'b1; start_addr = 4'd9; length = 5'd3; end
      if (k == 3) start = 1'b0;
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
          fails++; $display("FAIL bp_stable: valid=%b last=%b data=%h want 1/%b/%h", out_valid, out_last, out_data, held[8], held[7:0]);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bp_extra: unexpected word %h", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            fails++; $display("FAIL bp_word: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      held = {out_last, out_data};
      @(negedge clk); k++;
    end
    start = 1'b0;
    tests++;
    if (got != 5) begin fails++; $display("FAIL bp_timeout: got %0d words want 5", got); end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL bp_done: done=%b want 1", done); end
    repeat (4) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL bp_idle: valid=%b busy=%b left=%0d want 0/0/0", out_valid, busy, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int k, got, n;
    logic [8:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      n = (pass == 0) ? 4 : 16;
      out_ready = 1'b1;
      start_xfer(4'd14, 5'(n), 1'b0);
      k = 1; got = 0;
      while (got < n && k < 300) begin
        out_ready = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          got++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL wrap_extra: unexpected word %h", out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              fails++; $display("FAIL wrap_word: len=%0d got last=%b data=%h want last=%b data=%h", n, out_last, out_data, e[8], e[7:0]);
            end
          end
        end
        @(negedge clk); k++;
      end
      tests++;
      if (got != n || done !== 1'b1) begin
        fails++; $display("FAIL wrap_end: len=%0d got %0d words done=%b want %0d/1", n, got, done, n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_length();
    out_ready = 1'b1;
    start_xfer(4'd7, 5'd0, 1'b0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL zero_len: done=%b busy=%b valid=%b want 1/0/0", done, busy, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL zero_len_after: done=%b busy=%b valid=%b want 0/0/0", done, busy, out_valid);
      end
    end
  endtask

  task automatic test_reset_abort();
    int k, h;
    logic [8:0] e;
    out_ready = 1'b1;
    start_xfer(4'd5, 5'd8, 1'b0);
    k = 1; h = 0;
    while (h < 2 && k < 40) begin
      if (out_valid === 1'b1) begin
        h++;
        e = exp_q.pop_front();
        tests++;
        if ({out_last, out_data} !== e) begin
          fails++; $display("FAIL abort_word: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
        end
      end
      if (h < 2) begin @(negedge clk); k++; end
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    tests++;
    if ({bram_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
      fails++; $display("FAIL abort_reset: addr=%h valid=%b data=%h busy=%b done=%b want all 0", bram_addr, out_valid, out_data, busy, done);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL abort_stale: done=%b valid=%b want 0/0", done, out_valid);
      end
    end
    start_xfer(4'd0, 5'd2, 1'b0);
    k = 1; h = 0;
    while (h < 2 && k < 40) begin
      if (out_valid === 1'b1) begin
        h++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL abort_extra: unexpected word %h", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            fails++; $display("FAIL abort_restart: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      @(negedge clk); k++;
    end
    tests++;
    if (h != 2 || done !== 1'b1) begin fails++; $display("FAIL abort_done: words=%0d done=%b want 2/1", h, done); end
    @(negedge clk);
  endtask

`ifdef BRAM_READ_STREAMER_REVERSE_EN
  task automatic test_reverse();
    int k, got;
    logic [8:0] e;
    out_ready = 1'b1;
    start_xfer(4'd1, 5'd3, 1'b1);
    k = 1; got = 0;
    while (got < 3 && k < 40) begin
      if (out_valid === 1'b1) begin
        got++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rev_extra: unexpected word %h", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            fails++; $display("FAIL rev_word: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      @(negedge clk); k++;
    end
    tests++;
    if (got != 3 || done !== 1'b1) begin fails++; $display("FAIL rev_done: words=%0d done=%b want 3/1", got, done); end
    reverse = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_reset_abort();
`ifdef BRAM_READ_STREAMER_REVERSE_EN
    test_reverse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
